sdram_init: RTL and testbench

SDRAM_INIT -- requirements
Module: sdram_init

---
 rtl/sdram_init.sv | 143 ++++++++++++++
 tb/tb_sdram_init.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sdram_init.sv
// SDRAM power-up initialization sequencer.
//
// After reset release a 16-bit cycle counter runs from zero. A small FSM
// steps through the JEDEC power-up sequence:
//   wait -> PRECHARGE ALL -> tRP -> AUTO REFRESH -> tRC -> AUTO REFRESH
//   -> tRC -> LOAD MODE REGISTER -> tMRD -> done.
// Each step is triggered by comparing the counter against a fixed
// milestone, so the position of every command is known at elaboration time.
//
// Milestones (in init_cnt values):
//   P  = INIT_WAIT       PRECHARGE ALL  (Saddr[10] = 1)
//   R1 = P  + TRP        first AUTO REFRESH
//   R2 = R1 + TRC        second AUTO REFRESH
//   M  = R2 + TRC        LOAD MODE REGISTER  (Saddr = MODE_REG)
//   D  = M  + TMRD       Init_done rises, init_cnt freezes
//
// The state register advances on the same edge that moves the counter
// onto a milestone. Command, Saddr and Init_done are therefore pure
// decodes of the registered state and only change on a rising clock edge.
//
// Parameter constraints: INIT_WAIT, TRP, TRC and TMRD must each be at
// least 1, ASIZE at least 11 so that Saddr[10] exists, and D must not
// exceed 65535 because the counter is 16 bits wide and never wraps.

module sdram_init #(
  parameter int               ASIZE     = 12,
  parameter int               INIT_WAIT = 20000,
  parameter int               TRP       = 2,
  parameter int               TRC       = 7,
  parameter int               TMRD      = 2,
  parameter logic [ASIZE-1:0] MODE_REG  = 12'b00_0_00_011_0_010
) (
  input  logic             Clk,
  input  logic             Rst_n,
  output logic [3:0]       Command,
  output logic [ASIZE-1:0] Saddr,
  output logic             Init_done,
  output logic [15:0]      init_cnt
);

  // Command encodings {Cs_n, Ras_n, Cas_n, We_n}.
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  // Sequencer states.
  localparam logic [3:0] ST_WAIT   = 4'd0;
  localparam logic [3:0] ST_PRE    = 4'd1;
  localparam logic [3:0] ST_TRP_W  = 4'd2;
  localparam logic [3:0] ST_REF1   = 4'd3;
  localparam logic [3:0] ST_TRC1_W = 4'd4;
  localparam logic [3:0] ST_REF2   = 4'd5;
  localparam logic [3:0] ST_TRC2_W = 4'd6;
  localparam logic [3:0] ST_MRS    = 4'd7;
  localparam logic [3:0] ST_TMRD_W = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;

  // Milestones, computed as integers and then narrowed to counter width.
  localparam int MS_P  = INIT_WAIT;
  localparam int MS_R1 = MS_P  + TRP;
  localparam int MS_R2 = MS_R1 + TRC;
  localparam int MS_M  = MS_R2 + TRC;
  localparam int MS_D  = MS_M  + TMRD;

  localparam logic [15:0] CNT_P  = 16'(MS_P);
  localparam logic [15:0] CNT_R1 = 16'(MS_R1);
  localparam logic [15:0] CNT_R2 = 16'(MS_R2);
  localparam logic [15:0] CNT_M  = 16'(MS_M);
  localparam logic [15:0] CNT_D  = 16'(MS_D);

  logic [3:0]  state;
  logic [3:0]  state_next;
  logic [15:0] cnt_inc;

  assign cnt_inc = init_cnt + 16'd1;

  // Next-state logic: each transition fires when the counter is about to
  // land on the milestone of the target state. Spacing states are skipped
  // when the corresponding spacing is a single clock.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_next = state;
    case (state)
      ST_WAIT:   if (cnt_inc == CNT_P)  state_next = ST_PRE;
      ST_PRE:    state_next = (cnt_inc == CNT_R1) ? ST_REF1 : ST_TRP_W;
      ST_TRP_W:  if (cnt_inc == CNT_R1) state_next = ST_REF1;
      ST_REF1:   state_next = (cnt_inc == CNT_R2) ? ST_REF2 : ST_TRC1_W;
      ST_TRC1_W: if (cnt_inc == CNT_R2) state_next = ST_REF2;
      ST_REF2:   state_next = (cnt_inc == CNT_M)  ? ST_MRS  : ST_TRC2_W;
      ST_TRC2_W: if (cnt_inc == CNT_M)  state_next = ST_MRS;
      ST_MRS:    state_next = (cnt_inc == CNT_D)  ? ST_DONE : ST_TMRD_W;
      ST_TMRD_W: if (cnt_inc == CNT_D)  state_next = ST_DONE;
      ST_DONE:   state_next = ST_DONE;
      default:   state_next = ST_WAIT;
    endcase
  end

  // State and counter registers with synchronous active-low reset; the
  // counter freezes once the sequence reaches DONE.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values and simulation matches hardware.
    if (!Rst_n) begin
      state    <= ST_WAIT;
      init_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (state != ST_DONE) begin
        init_cnt <= cnt_inc;
      end
    end
  end

  // Output decode of the registered state: one command cycle per
  // command state, NOP with a zero address bus everywhere else.
  always_comb begin
    Command   = CMD_NOP;
    Saddr     = '0;
    Init_done = 1'b0;
    case (state)
      ST_PRE: begin
        Command   = CMD_PRECHARGE;
        Saddr[10] = 1'b1;
      end
      ST_REF1, ST_REF2: begin
        Command = CMD_AUTO_REFRESH;
      end
      ST_MRS: begin
        Command = CMD_LOAD_MODE;
        Saddr   = MODE_REG;
      end
      ST_DONE: begin
        Init_done = 1'b1;
      end
      default: begin
        Command = CMD_NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_init.sv
// Directed testbench for sdram_init with default parameters.
//
// Every cycle after reset release the bench tracks its own expected
// counter value and derives the expected command, address and done flag
// from hand-computed milestones (20000, 20002, 20009, 20016, 20018).
// Scenarios: long reset, full sequence plus 2000 ns idle after done,
// reset pulse after done, reset pulse at init_cnt 20005, and a final full
// sequence after that restart.

module tb_sdram_init;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;

  logic        Clk;
  logic        Rst_n;
  logic [3:0]  Command;
  logic [11:0] Saddr;
  logic        Init_done;
  logic [15:0] init_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_cnt  = 0;
  bit exp_done = 1'b0;

  // Observed command occurrences in the current run.
  int n_pre = 0;
  int n_ref = 0;
  int n_lmr = 0;

  sdram_init dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Command  (Command),
    .Saddr    (Saddr),
    .Init_done(Init_done),
    .init_cnt (init_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare all outputs against the expected values for exp_cnt.
  task automatic check_cycle();
    logic [3:0]  e_cmd;
    logic [11:0] e_addr;
    e_cmd  = NOP;
    e_addr = 12'h000;
    case (exp_cnt)
      20000: begin e_cmd = PRE;  e_addr = 12'h400; end
      20002: e_cmd = AREF;
      20009: e_cmd = AREF;
      20016: begin e_cmd = LMR;  e_addr = 12'h032; end
      default: e_cmd = NOP;
    endcase
    check($sformatf("init_cnt@%0d", exp_cnt), 32'(init_cnt), 32'(exp_cnt));
    check($sformatf("command@%0d", exp_cnt), 32'(Command), 32'(e_cmd));
    check($sformatf("saddr@%0d", exp_cnt), 32'(Saddr), 32'(e_addr));
    check($sformatf("init_done@%0d", exp_cnt), 32'(Init_done), 32'(exp_done));
    if (Command == PRE)  n_pre++;
    if (Command == AREF) n_ref++;
    if (Command == LMR)  n_lmr++;
  endtask

  // One clock: advance the expected counter the way the DUT should, then
  // sample on the falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    if (!exp_done) exp_cnt++;
    exp_done = (exp_cnt >= 20018);
    check_cycle();
  endtask

  // Hold reset for n clocks from a falling edge, check reset values,
  // release on a falling edge and restart the expected model.
  task automatic reset_for(input int n);
    Rst_n = 1'b0;
    repeat (n) @(posedge Clk);
    @(negedge Clk);
    check("rst_cnt",  32'(init_cnt),  32'd0);
    check("rst_cmd",  32'(Command),   32'(NOP));
    check("rst_addr", 32'(Saddr),     32'd0);
    check("rst_done", 32'(Init_done), 32'd0);
    Rst_n    = 1'b1;
    exp_cnt  = 0;
    exp_done = 1'b0;
    n_pre    = 0;
    n_ref    = 0;
    n_lmr    = 0;
    check_cycle();
  endtask

  // Run to done, then 200 more clocks (2000 ns) of idle, and check
  // the totals of each command type.
  task automatic run_full(input string name);
    for (int i = 0; i < 20018 + 200; i++) step();
    check({name, "_pre_count"}, 32'(n_pre), 32'd1);
    check({name, "_ref_count"}, 32'(n_ref), 32'd2);
    check({name, "_lmr_count"}, 32'(n_lmr), 32'd1);
    check({name, "_final_cnt"}, 32'(init_cnt), 32'd20018);
    check({name, "_final_done"}, 32'(Init_done), 32'd1);
  endtask

  initial begin
    Rst_n = 1'b0;
    @(negedge Clk);
    reset_for(200);
    run_full("run1");

    // Reset after done restarts the sequence.
    reset_for(1);
    for (int i = 0; i < 20005; i++) step();
    check("mid_cnt", 32'(init_cnt), 32'd20005);
    check("mid_pre_count", 32'(n_pre), 32'd1);
    check("mid_ref_count", 32'(n_ref), 32'd1);

    // One-clock reset pulse mid-sequence, then a full rerun.
    reset_for(1);
    run_full("run3");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
